// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer for one oscilloscope channel: writes the sample
// buffer around a level/slope trigger and freezes it for display.
module scope_capture_ctrl #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 11,
  parameter int DEPTH       = 640,
  parameter int PRE_DEFAULT = 160,
  parameter int AUTO_TO     = 2048,
  parameter int HOLD_FRAMES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              frame_done,
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              hold,
  output logic              triggered,
  output logic [1:0]        state
);

  localparam logic [1:0] S_PREFILL = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_POST    = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;
  localparam logic [1:0] M_AUTO    = 2'b00;
  localparam logic [1:0] M_SINGLE  = 2'b10;
  localparam logic [1:0] M_STOP    = 2'b11;

  localparam int AC_W = $clog2(AUTO_TO + 1);
  localparam int FC_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [ADDR_W-1:0] P_MAX    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] P_RST    = ADDR_W'((PRE_DEFAULT < DEPTH - 1) ? PRE_DEFAULT : DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [AC_W-1:0]   AUTO_MAX = AC_W'(AUTO_TO);
  localparam logic [FC_W-1:0]   FRAMES   = FC_W'(HOLD_FRAMES);

  logic [ADDR_W-1:0] ptr, p, pre_cnt, post_cnt, trig_addr;
  logic [AC_W-1:0]   auto_cnt;
  logic [FC_W-1:0]   frame_cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid, stopped;
  logic              accept, real_trig, force_trig, to_stop, hold_release;
  logic [ADDR_W-1:0] ptr_next, p_clamp, post_load;

  // Oldest displayed sample: (t - pre) modulo the buffer depth, not 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] window_start(input logic [ADDR_W-1:0] t,
                                                     input logic [ADDR_W-1:0] pre);
    logic [ADDR_W:0] s;
    s = {1'b0, t} + DEPTH_X - {1'b0, pre};
    return (s >= DEPTH_X) ? ADDR_W'(s - DEPTH_X) : s[ADDR_W-1:0];
  endfunction

  // Per-cycle decode of acceptance, trigger detection and hold release.
  always_comb begin
    accept     = sample_en && (state != S_HOLD);
    ptr_next   = (ptr == P_MAX) ? '0 : ptr + 1'b1;
    p_clamp    = (pretrig > P_MAX) ? P_MAX : pretrig;
    post_load  = P_MAX - p;
    to_stop    = (trig_mode == M_STOP);
    force_trig = (trig_mode == M_AUTO) && (auto_cnt == AUTO_MAX);
    if (!prev_valid) begin
      real_trig = 1'b0;
    end else if (trig_slope) begin
      real_trig = (prev > trig_level) && (sample_data <= trig_level);
    end else begin
      real_trig = (prev < trig_level) && (sample_data >= trig_level);
    end
    if (stopped) begin
      hold_release = 1'b1;
    end else if (trig_mode == M_SINGLE) begin
      hold_release = arm;
    end else begin
      hold_release = frame_done && (frame_cnt + 1'b1 >= FRAMES);
    end
  end

  // Capture sequencer, registered write port and display controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start_addr <= '0;
      hold       <= 1'b0;
      triggered  <= 1'b0;
      state      <= S_PREFILL;
      ptr        <= '0;
      p          <= P_RST;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      auto_cnt   <= '0;
      frame_cnt  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      stopped    <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr    <= ptr;
        wr_data    <= sample_data;
        ptr        <= ptr_next;
        prev       <= sample_data;
        prev_valid <= 1'b1;
      end
      if (to_stop && (state != S_HOLD)) begin
        // A sample accepted this cycle is kept, so the oldest sample is past it.
        state      <= S_HOLD;
        hold       <= 1'b1;
        triggered  <= 1'b0;
        stopped    <= 1'b1;
        frame_cnt  <= '0;
        start_addr <= accept ? ptr_next : ptr;
      end else begin
        case (state)
          S_PREFILL: begin
            if ((p == '0) || (accept && (pre_cnt + 1'b1 == p))) begin
              state    <= S_ARMED;
              auto_cnt <= '0;
            end else if (accept) begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          S_ARMED: begin
            if (accept && (real_trig || force_trig)) begin
              triggered <= real_trig;
              trig_addr <= ptr;
              post_cnt  <= post_load;
              if (post_load == '0) begin
                state      <= S_HOLD;
                hold       <= 1'b1;
                frame_cnt  <= '0;
                start_addr <= window_start(ptr, p);
              end else begin
                state <= S_POST;
              end
            end else if (accept && (auto_cnt != AUTO_MAX)) begin
              auto_cnt <= auto_cnt + 1'b1;
            end
          end
          S_POST: begin
            if (accept) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == ADDR_W'(1)) begin
                state      <= S_HOLD;
                hold       <= 1'b1;
                frame_cnt  <= '0;
                start_addr <= window_start(trig_addr, p);
              end
            end
          end
          S_HOLD: begin
            if (to_stop) begin
              stopped <= 1'b1;
            end else if (hold_release) begin
              state      <= S_PREFILL;
              hold       <= 1'b0;
              stopped    <= 1'b0;
              p          <= p_clamp;
              pre_cnt    <= '0;
              prev_valid <= 1'b0;
            end else if (frame_done && (trig_mode != M_SINGLE)) begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: state <= S_PREFILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Randomised scoreboard bench for scope_capture_ctrl: a behavioural model
// predicts every cycle's outputs and every buffer write.
module tb_scope_capture_ctrl;
  localparam int DW = 12, AW = 6, DEPTH = 16, PRE_D = 4, ATO = 8, HF = 1;

  logic          clock = 1'b0, reset = 1'b0, sample_en = 1'b0;
  logic [DW-1:0] sample_data = '0, trig_level = '0;
  logic          trig_slope = 1'b0;
  logic [1:0]    trig_mode = 2'b01;
  logic [AW-1:0] pretrig = 6'd4;
  logic          frame_done = 1'b0, arm = 1'b0;
  logic          wr_en, hold, triggered;
  logic [AW-1:0] wr_addr, start_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    state;

  scope_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PRE_DEFAULT(PRE_D),
                       .AUTO_TO(ATO), .HOLD_FRAMES(HF)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .sample_data(sample_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode),
    .pretrig(pretrig), .frame_done(frame_done), .arm(arm), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start_addr(start_addr), .hold(hold),
    .triggered(triggered), .state(state));

  always #5 clock = ~clock;

  typedef struct { int st; int hold; int trig; int start; int wen; } cyc_t;
  typedef struct { int addr; int data; } wr_t;
  cyc_t cq[$];
  wr_t  wq[$];

  int checks = 0, errors = 0;
  int post_seen = 0, post_wr = 0, last_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 prefill, 1 armed, 2 post, 3 hold.
  int m_phase, m_p, n_pre, n_arm, n_post, m_ptr, m_prev, m_have_prev;
  int m_T, m_frames, m_stopped, m_trig, m_start, m_hold;

  function automatic void model_reset();
    m_phase = 0; m_p = (PRE_D < DEPTH - 1) ? PRE_D : DEPTH - 1;
    n_pre = 0; n_arm = 0; n_post = 0; m_ptr = 0; m_prev = 0; m_have_prev = 0;
    m_T = 0; m_frames = 0; m_stopped = 0; m_trig = 0; m_start = 0; m_hold = 0;
  endfunction

  function automatic void go_hold(input int start);
    m_phase = 3; m_hold = 1; m_start = start; m_frames = 0;
  endfunction

  function automatic void enter_prefill();
    m_phase = 0; m_hold = 0; m_stopped = 0; n_pre = 0; m_have_prev = 0;
    m_p = (int'(pretrig) > DEPTH - 1) ? DEPTH - 1 : int'(pretrig);
  endfunction

  function automatic void model_step();
    int acc, nptr, real_t, forced;
    wr_t w;
    cyc_t c;
    acc  = (sample_en && m_phase != 3) ? 1 : 0;
    nptr = acc ? (m_ptr + 1) % DEPTH : m_ptr;
    if (acc != 0) begin
      w.addr = m_ptr; w.data = int'(sample_data);
      wq.push_back(w);
    end
    if (trig_mode == 2'b11 && m_phase != 3) begin
      m_trig = 0; m_stopped = 1; go_hold(nptr);
    end else begin
      case (m_phase)
        0: begin
          if (m_p == 0) begin m_phase = 1; n_arm = 0; end
          else if (acc != 0) begin
            n_pre++;
            if (n_pre == m_p) begin m_phase = 1; n_arm = 0; end
          end
        end
        1: if (acc != 0) begin
          if (trig_slope) real_t = (m_have_prev != 0 && m_prev > int'(trig_level) && int'(sample_data) <= int'(trig_level)) ? 1 : 0;
          else            real_t = (m_have_prev != 0 && m_prev < int'(trig_level) && int'(sample_data) >= int'(trig_level)) ? 1 : 0;
          forced = (trig_mode == 2'b00 && n_arm >= ATO) ? 1 : 0;
          if (real_t != 0 || forced != 0) begin
            m_trig = real_t; m_T = m_ptr;
            if (m_p == DEPTH - 1) go_hold((m_T + DEPTH - m_p) % DEPTH);
            else begin m_phase = 2; n_post = 0; end
          end else n_arm++;
        end
        2: if (acc != 0) begin
          n_post++;
          if (n_post == DEPTH - 1 - m_p) go_hold((m_T + DEPTH - m_p) % DEPTH);
        end
        default: begin
          if (trig_mode == 2'b11) m_stopped = 1;
          else if (m_stopped != 0) enter_prefill();
          else if (trig_mode == 2'b10) begin
            if (arm) enter_prefill();
          end else if (frame_done) begin
            m_frames++;
            if (m_frames >= HF) enter_prefill();
          end
        end
      endcase
    end
    if (acc != 0) begin m_prev = int'(sample_data); m_have_prev = 1; end
    m_ptr = nptr;
    c.st = m_phase; c.hold = m_hold; c.trig = m_trig; c.start = m_start; c.wen = acc;
    cq.push_back(c);
  endfunction

  cyc_t mc;
  wr_t  mw;
  // Monitor: one expected record per clock, one expected write per wr_en pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (state == 2'd2) begin
        post_seen++;
        if (wr_en) post_wr++;
      end
      if (wr_en) last_wr = int'(wr_addr);
      if (cq.size() > 0) begin
        mc = cq.pop_front();
        check("state", state, mc.st);
        check("hold", hold, mc.hold);
        check("triggered", triggered, mc.trig);
        check("start_addr", start_addr, mc.start);
        check("wr_en", wr_en, mc.wen);
        if (wr_en) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected got addr %0d expected no write", wr_addr);
          end else begin
            mw = wq.pop_front();
            check("wr_addr", wr_addr, mw.addr);
            check("wr_data", wr_data, mw.data);
          end
        end
      end
    end
  end

  // Stimulus generator settings.
  int cyc = 0, cfg_period = 3, cfg_kind = 0, cfg_step = 10, cfg_dc = 0, cfg_fd = 0, ramp = 0;
  logic force_fd = 1'b0;

  task automatic tick();
    if (cfg_period == 0) sample_en = (($urandom % 2) == 1);
    else                 sample_en = ((cyc % cfg_period) == 0);
    if (trig_mode == 2'b11 && m_phase != 3) sample_en = 1'b0;
    if (sample_en) begin
      case (cfg_kind)
        0:       begin sample_data = DW'(ramp); ramp += cfg_step; end
        1:       sample_data = DW'(cfg_dc);
        default: sample_data = DW'($urandom_range(4095, 0));
      endcase
    end
    frame_done = force_fd || (cfg_fd > 0 && (cyc % cfg_fd) == cfg_fd - 1);
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    force_fd = 1'b0;
    arm = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin tick(); n++; end
    if (m_phase != ph) begin
      checks++; errors++;
      $display("FAIL %s timeout got phase %0d expected %0d", name, m_phase, ph);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_en = 1'b0; frame_done = 1'b0; arm = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_start", start_addr, 32'd0);
    check("rst_hold", hold, 32'd0);
    check("rst_trig", triggered, 32'd0);
    check("rst_state", state, 32'd0);
    cq.delete(); wq.delete();
    model_reset();
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
  endtask

  int base;
  initial begin
    model_reset();
    @(negedge clock);
    do_reset();

    // Rising ramp, normal mode: 60 lands at address 6, window starts at 2.
    trig_mode = 2'b01; trig_level = 12'd55; trig_slope = 1'b0; pretrig = 6'd4;
    cfg_period = 3; cfg_kind = 0; ramp = 0; cfg_step = 10;
    wait_phase(3, 200, "rise_hold");
    check("rise_start", start_addr, 32'd2);
    check("rise_trig", triggered, 32'd1);
    check("rise_hold", hold, 32'd1);

    // Falling ramp: trigger at address 14, window wraps and ends at 9.
    do_reset();
    trig_slope = 1'b1; trig_level = 12'd60; cfg_period = 2; ramp = 200; cfg_step = -10;
    wait_phase(3, 200, "fall_hold");
    check("fall_start", start_addr, 32'd10);
    check("fall_last_write", last_wr, 32'd9);

    // Auto timeout on a DC input that never crosses the level.
    trig_mode = 2'b00; cfg_kind = 1; cfg_dc = 100; trig_level = 12'd500; trig_slope = 1'b0;
    force_fd = 1'b1; tick();
    wait_phase(3, 200, "auto_hold");
    check("auto_trig", triggered, 32'd0);
    force_fd = 1'b1; tick(); #1;
    check("auto_release", state, 32'd0);

    // Single mode: frames do not release, arm does.
    trig_mode = 2'b10; cfg_kind = 2; trig_level = 12'd2048;
    wait_phase(3, 500, "single_hold");
    for (int i = 0; i < 3; i++) begin force_fd = 1'b1; tick(); tick(); end
    #1;
    check("single_still_hold", state, 32'd3);
    pretrig = 6'd40; arm = 1'b1; force_fd = 1'b1; tick(); #1;
    check("single_arm", state, 32'd0);

    // Clamped pretrig: ARMED goes straight to HOLD.
    trig_mode = 2'b01; base = post_seen;
    wait_phase(3, 800, "clamp_hold");
    check("clamp_no_post", post_seen - base, 32'd0);
    check("clamp_start", start_addr, (m_T + 1) % DEPTH);

    // Zero pretrig: trigger write plus 14 further writes seen while in POST.
    pretrig = 6'd0; force_fd = 1'b1; tick();
    base = post_wr;
    wait_phase(3, 800, "zero_hold");
    check("zero_post_writes", post_wr - base, 32'd15);

    // Stop during POST freezes at the current write pointer.
    pretrig = 6'd8; force_fd = 1'b1; tick();
    wait_phase(2, 800, "stop_post");
    trig_mode = 2'b11; tick(); #1;
    check("stop_state", state, 32'd3);
    check("stop_start", start_addr, (last_wr + 1) % DEPTH);
    check("stop_trig", triggered, 32'd0);
    for (int i = 0; i < 4; i++) begin force_fd = 1'b1; tick(); end
    #1;
    check("stop_stays", state, 32'd3);
    trig_mode = 2'b01; tick(); #1;
    check("stop_leave", state, 32'd0);

    // Reset in the middle of ARMED.
    wait_phase(1, 200, "armed_before_reset");
    do_reset();

    // Randomised traffic across modes, levels and pretrigger values.
    cfg_period = 0; cfg_kind = 2; cfg_fd = 25;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49, 0) == 0) trig_mode = 2'($urandom_range(3, 0));
      if ($urandom_range(29, 0) == 0) pretrig = 6'($urandom_range(20, 0));
      if ($urandom_range(29, 0) == 0) trig_level = 12'($urandom_range(4095, 0));
      if ($urandom_range(29, 0) == 0) trig_slope = 1'($urandom_range(1, 0));
      arm = ($urandom_range(39, 0) == 0);
      tick();
    end

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
